// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller with HI/LO registers.
//
// Runs mult/multu/div/divu as fixed-latency operations. Busy is high for
// exactly MULT_CYCLES or DIV_CYCLES cycles, then Hi/Lo are written and Done
// pulses for one cycle. mthi/mtlo write Hi/Lo directly from A when idle.
// Stall asks the front of the pipeline to freeze whenever a HI/LO-class
// instruction in decode would collide with an operation that is starting
// or already in flight.
//
// Ports:
//   Clk    - system clock, all state updates on its rising edge
//   Reset  - synchronous active-high reset
//   Start  - issue the operation on Op/A/B this cycle
//   Op     - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//            110/111 reserved (ignored)
//   A, B   - operands (rs, rt)
//   MdUse  - instruction in decode is HI/LO-class
//   Busy   - mult/div in progress
//   Stall  - combinational pipeline freeze request
//   Done   - one-cycle pulse, new Hi/Lo values visible
//   Hi, Lo - architectural HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MdUse,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state, nextState;
  logic [CW-1:0] count, nextCount;
  logic          finish;

  logic [31:0]   opA, opB;
  logic          isSigned;

  logic          issueMd;
  logic [63:0]   extA, extB, product;
  logic [31:0]   absA, absB, safeDivisor, uQuo, uRem, quo, rem;
  logic          negQuo, negRem;

  // An accepted Start only matters in IDLE; Start while busy is dropped.
  assign issueMd = Start && (Op[2] == 1'b0);
  assign Busy    = (state != IDLE);
  assign Stall   = MdUse && (Busy || issueMd);

  // Next-state and down-counter logic. The counter is loaded with the full
  // latency on issue and the operation finishes during the cycle where it
  // reads 1, so Busy covers exactly that many cycles.
  always_comb begin
    nextState = state;
    nextCount = count;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (Start && (Op[2:1] == 2'b00)) begin
          nextState = MULT;
          nextCount = CW'(MULT_CYCLES);
        end else if (Start && (Op[2:1] == 2'b01)) begin
          nextState = DIV;
          nextCount = CW'(DIV_CYCLES);
        end
      end
      MULT, DIV: begin
        if (count <= CW'(1)) begin
          finish    = 1'b1;
          nextState = IDLE;
          nextCount = '0;
        end else begin
          nextCount = count - CW'(1);
        end
      end
      default: begin
        nextState = IDLE;
        nextCount = '0;
      end
    endcase
  end

  // State and counter registers; reset wins over everything else.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  // Result arithmetic on the latched operands. Sign-extending (or
  // zero-extending) both operands to 64 bits lets one multiplier serve both
  // mult and multu. Division is done on magnitudes and the signs are fixed
  // up afterwards: quotient truncates toward zero, remainder follows the
  // dividend. The most negative value divided by -1 naturally wraps to
  // 0x80000000 with a zero remainder.
  always_comb begin
    extA        = {{32{isSigned & opA[31]}}, opA};
    extB        = {{32{isSigned & opB[31]}}, opB};
    product     = extA * extB;
    absA        = (isSigned && opA[31]) ? (~opA + 32'd1) : opA;
    absB        = (isSigned && opB[31]) ? (~opB + 32'd1) : opB;
    safeDivisor = (absB == 32'd0) ? 32'd1 : absB;
    uQuo        = absA / safeDivisor;
    uRem        = absA % safeDivisor;
    negQuo      = isSigned && (opA[31] ^ opB[31]);
    negRem      = isSigned && opA[31];
    quo         = negQuo ? (~uQuo + 32'd1) : uQuo;
    rem         = negRem ? (~uRem + 32'd1) : uRem;
  end

  // Operand latch, HI/LO registers and the Done pulse. Operands are
  // captured only on an accepted mult/div issue, so later changes on A/B
  // cannot disturb the result. A zero divisor still runs the full latency
  // and pulses Done but leaves HI/LO untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      opA      <= '0;
      opB      <= '0;
      isSigned <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= finish;
      if (state == IDLE && Start) begin
        if (Op[2] == 1'b0) begin
          opA      <= A;
          opB      <= B;
          isSigned <= ~Op[0];
        end else if (Op == 3'b100) begin
          Hi <= A;
        end else if (Op == 3'b101) begin
          Lo <= A;
        end
      end
      if (finish) begin
        if (state == MULT) begin
          Hi <= product[63:32];
          Lo <= product[31:0];
        end else if (opB != 32'd0) begin
          Hi <= rem;
          Lo <= quo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl.
//
// Keeps an architectural model of HI/LO computed with 64-bit integer
// arithmetic, drives directed scenarios followed by random operations, and
// compares Busy/Done/Stall/Hi/Lo cycle by cycle. Inputs change on the
// falling clock edge; outputs are sampled 1 time unit after it.
module tb_mdu_ctrl;

  localparam int MULTC = 5;
  localparam int DIVC  = 10;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        MdUse;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  logic [31:0] expHi, expLo;
  int          compared = 0;
  int          mismatched = 0;

  mdu_ctrl #(.MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .MdUse(MdUse), .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  // 10-unit clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Architectural reference: what HI/LO hold after an operation completes
  function automatic void modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, res;
    logic [63:0] bits;
    case (op)
      3'd0, 3'd1: begin
        if (op == 3'd0) begin
          sa = $signed(a);
          sb = $signed(b);
        end else begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        res   = sa * sb;
        bits  = res;
        expHi = bits[63:32];
        expLo = bits[31:0];
      end
      3'd2, 3'd3: begin
        if (b != 32'd0) begin
          if (op == 3'd2) begin
            sa = $signed(a);
            sb = $signed(b);
          end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          res   = sa / sb;
          bits  = res;
          expLo = bits[31:0];
          res   = sa % sb;
          bits  = res;
          expHi = bits[31:0];
        end
      end
      3'd4: expHi = a;
      3'd5: expLo = a;
      default: ;
    endcase
  endfunction

  // Issue one operation at the current falling edge and follow it to the
  // end. For mult/div the task returns at the Done cycle (after checking it),
  // so a caller may issue again immediately. intrudeAt > 0 asserts Start
  // with intrudeOp during that busy cycle, which must be ignored.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int intrudeAt, input logic [2:0] intrudeOp);
    logic [31:0] oldHi, oldLo;
    int n;
    oldHi = expHi;
    oldLo = expLo;
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    #1;
    checkOutput("stall_issue", Stall, MdUse & (op < 3'd4));
    modelOp(op, a, b);
    @(negedge Clk);
    Start = 1'b0;
    if (op < 3'd4) begin
      n = (op < 3'd2) ? MULTC : DIVC;
      for (int k = 1; k <= n; k++) begin
        if (k == intrudeAt) begin
          Start = 1'b1;
          Op    = intrudeOp;
        end else begin
          Start = 1'b0;
        end
        A = $urandom;
        B = $urandom;
        #1;
        checkOutput("busy_on", Busy, 1'b1);
        checkOutput("done_low_busy", Done, 1'b0);
        checkOutput("stall_busy", Stall, MdUse);
        checkOutput("hi_hold_busy", Hi, oldHi);
        checkOutput("lo_hold_busy", Lo, oldLo);
        @(negedge Clk);
      end
      Start = 1'b0;
      #1;
      checkOutput("busy_off", Busy, 1'b0);
      checkOutput("done_pulse", Done, 1'b1);
      checkOutput("hi_result", Hi, expHi);
      checkOutput("lo_result", Lo, expLo);
    end else begin
      #1;
      checkOutput("busy_mt", Busy, 1'b0);
      checkOutput("done_mt", Done, 1'b0);
      checkOutput("hi_mt", Hi, expHi);
      checkOutput("lo_mt", Lo, expLo);
    end
  endtask

  // One quiet cycle: nothing in flight, no Done, HI/LO hold
  task automatic idleCycle();
    @(negedge Clk);
    Start = 1'b0;
    #1;
    checkOutput("idle_busy", Busy, 1'b0);
    checkOutput("idle_done", Done, 1'b0);
    checkOutput("idle_stall", Stall, 1'b0);
    checkOutput("idle_hi", Hi, expHi);
    checkOutput("idle_lo", Lo, expLo);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 3'd0;
    A     = '0;
    B     = '0;
    MdUse = 1'b0;
    expHi = '0;
    expLo = '0;

    // Reset state, and Stall follows MdUse & Start & mult/div during reset
    repeat (3) @(negedge Clk);
    MdUse = 1'b1;
    Start = 1'b1;
    Op    = 3'd2;
    #1;
    checkOutput("rst_busy", Busy, 1'b0);
    checkOutput("rst_done", Done, 1'b0);
    checkOutput("rst_hi", Hi, 32'h0);
    checkOutput("rst_lo", Lo, 32'h0);
    checkOutput("rst_stall", Stall, 1'b1);
    @(negedge Clk);
    Start = 1'b0;
    MdUse = 1'b0;
    Reset = 1'b0;
    idleCycle();

    // Signed mult 3 * -2
    @(negedge Clk);
    applyStimulus(3'd0, 32'd3, 32'hFFFFFFFE, 0, 3'd0);
    checkOutput("mult_hi_const", Hi, 32'hFFFFFFFF);
    checkOutput("mult_lo_const", Lo, 32'hFFFFFFFA);
    idleCycle();

    // multu max*max, with a div Start in busy cycle 2 that must be ignored
    @(negedge Clk);
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 3'd2);
    checkOutput("multu_hi_const", Hi, 32'hFFFFFFFE);
    checkOutput("multu_lo_const", Lo, 32'h00000001);
    idleCycle();

    // Signed div -7 / 2 with MdUse held high
    MdUse = 1'b1;
    @(negedge Clk);
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 0, 3'd0);
    checkOutput("div_stall_after", Stall, 1'b0);
    checkOutput("div_lo_const", Lo, 32'hFFFFFFFD);
    checkOutput("div_hi_const", Hi, 32'hFFFFFFFF);
    MdUse = 1'b0;
    idleCycle();

    // mthi, mtlo, then divu by zero leaves them alone
    @(negedge Clk);
    applyStimulus(3'd4, 32'h12345678, $urandom, 0, 3'd0);
    applyStimulus(3'd5, 32'h9ABCDEF0, $urandom, 0, 3'd0);
    applyStimulus(3'd3, $urandom, 32'd0, 0, 3'd0);
    checkOutput("div0_hi_const", Hi, 32'h12345678);
    checkOutput("div0_lo_const", Lo, 32'h9ABCDEF0);
    idleCycle();

    // Reserved opcodes have no effect
    @(negedge Clk);
    applyStimulus(3'd6, $urandom, $urandom, 0, 3'd0);
    applyStimulus(3'd7, $urandom, $urandom, 0, 3'd0);
    idleCycle();

    // div 100/7 aborted by reset in busy cycle 3
    @(negedge Clk);
    Start = 1'b1;
    Op    = 3'd2;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    expHi = '0;
    expLo = '0;
    #1;
    checkOutput("abort_busy", Busy, 1'b0);
    checkOutput("abort_hi", Hi, 32'h0);
    checkOutput("abort_lo", Lo, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      #1;
      checkOutput("abort_no_done", Done, 1'b0);
    end

    // Overflow case, then a back-to-back issue in the Done cycle
    @(negedge Clk);
    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0);
    checkOutput("ovf_lo_const", Lo, 32'h80000000);
    checkOutput("ovf_hi_const", Hi, 32'h00000000);
    applyStimulus(3'd0, $urandom, $urandom, 0, 3'd0);
    idleCycle();

    // Random operations with random MdUse, intrusions and idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          sel;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      if (sel == 2) rb = 32'($urandom_range(1, 9));
      MdUse = 1'($urandom_range(0, 1));
      @(negedge Clk);
      applyStimulus(rop, ra, rb, $urandom_range(0, 6), 3'($urandom_range(0, 5)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        MdUse = 1'b0;
        idleCycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: cycles Busy is high for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: cycles Busy is high for div/divu.
REQ-003 SHALL have port Clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on the Clk rising edge.
REQ-005 SHALL have port Start  input  1  issues the operation on Op/A/B this cycle.
REQ-006 SHALL have port Op  input  3  operation select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are reserved.
REQ-007 SHALL have port A  input  32  first operand (rs): multiplicand, dividend, or mthi/mtlo data.
REQ-008 SHALL have port B  input  32  second operand (rt): multiplier or divisor.
REQ-009 SHALL have port MdUse  input  1  the instruction in decode is HI/LO-class (mult*, div*, mfhi, mflo, mthi, mtlo).
REQ-010 SHALL have port Busy  output  1  a mult/div operation is in progress.
REQ-011 SHALL have port Stall  output  1  request to freeze the front of the pipeline.
REQ-012 SHALL have port Done  output  1  one-cycle pulse; new Hi/Lo values are visible.
REQ-013 SHALL have port Hi  output  32  registered HI register.
REQ-014 SHALL have port Lo  output  32  registered LO register.

Function
REQ-015 SHALL implement states IDLE, MULT and DIV, plus a down-counter wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-016 In IDLE, Start with Op 000/001 SHALL latch A and B, load the counter with MULT_CYCLES, and enter MULT; Op 010/011 SHALL do the same with DIV_CYCLES and enter DIV.
REQ-017 Timing SHALL be exact: Start sampled at edge t → Busy=1 in cycles t+1..t+N; Hi/Lo written at the edge that ends cycle t+N; Busy=0 and Done=1 in cycle t+N+1.
REQ-018 Busy SHALL be 1 exactly when state is not IDLE; Done SHALL be registered and high for one cycle only.
REQ-019 mult SHALL compute the signed 32x32 → 64-bit product and multu the unsigned product; Hi = bits 63:32, Lo = bits 31:0.
REQ-020 div/divu SHALL set Lo = quotient and Hi = remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0x00000000.
REQ-022 A divisor of 0 SHALL still occupy DIV_CYCLES and pulse Done, but SHALL leave Hi and Lo unchanged.
REQ-023 In IDLE, Start with mthi (100) SHALL write A into Hi at that edge, and mtlo (101) SHALL write A into Lo; neither raises Busy or Done.
REQ-024 Start with Op 110/111 SHALL have no effect.
REQ-025 Start while Busy=1 SHALL be ignored: no relatch, no counter reload, no Hi/Lo write.
REQ-026 Stall SHALL be combinational and equal MdUse & (Busy | (Start & Op is 000–011)).
REQ-027 Hi and Lo SHALL change only on a mult/div completion, mthi/mtlo, or Reset; otherwise they hold.
REQ-028 Operand changes on A/B after the Start edge SHALL NOT affect the result.

Reset
REQ-029 On Reset=1 at a rising edge, the block SHALL set state to IDLE, counter to 0, and Busy, Done, Hi and Lo to 0; Stall then equals MdUse & Start & Op is 000–011.
REQ-030 Reset SHALL take priority over Start and over completion in the same cycle; an aborted operation SHALL produce no Done and no Hi/Lo write.

Verification
REQ-031 Reset, then mult A=3 B=0xFFFFFFFE → Busy=1 for 5 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, Done=1 for exactly one cycle.
REQ-032 multu A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001 after 5 busy cycles; Start with div in busy cycle 2 → ignored, Hi/Lo unchanged by it.
REQ-033 div A=0xFFFFFFF9 (-7) B=2, MdUse=1 throughout → Stall=1 in the issue cycle plus 10 busy cycles, 0 after; Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-034 mthi A=0x12345678 then mtlo A=0x9ABCDEF0, then divu B=0 → Busy for 10 cycles, Done pulses, Hi=0x12345678 and Lo=0x9ABCDEF0 unchanged.
REQ-035 div 100/7 with Reset asserted in busy cycle 3 → next cycle Busy=0, Hi=Lo=0, and no Done in the following 10 cycles.
REQ-036 Signed div 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0; back-to-back Start in the Done cycle is accepted and Busy rises in the next cycle.
